serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/full_adder.sv | 15 +
 rtl/serial_adder_ctrl.sv | 96 +++++++++
 tb/tb_serial_adder_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell shared by the serial controller.
module full_adder (
    output logic s,
    output logic co,
    input  logic a,
    input  logic b,
    input  logic c
);

    always_comb begin
        s  = a ^ b ^ c;
        co = (a & b) | (a & c) | (b & c);
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder cell walks the operands LSB first, one bit per clock,
// with a registered carry between bits and a start/busy/done handshake.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_co;

    full_adder u_fa (
        .s  (fa_s),
        .co (fa_co),
        .a  (sa[0]),
        .b  (sb[0]),
        .c  (carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sa    <= '0;
            sb    <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        carry <= cin;
                        cnt   <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    // Concatenate-then-shift keeps the WIDTH=1 case free of a reversed slice.
                    sum   <= WIDTH'({fa_s, sum} >> 1);
                    carry <= fa_co;
                    if (cnt == LAST) begin
                        // Counter parks at zero so it never runs past the last bit index.
                        cnt   <= '0;
                        cout  <= fa_co;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed checks of serial_adder_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       cin1 = 1'b0;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one 8-bit addition, then check latency, busy length, result and done width.
    task automatic add8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic cv, input logic [7:0] exp_sum, input logic exp_cout);
        int lat;
        int busy_cycles;
        a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        a8 = ~av; b8 = ~bv; cin8 = ~cv;
        lat = 1;
        busy_cycles = 0;
        while (!done8 && lat < 40) begin
            if (busy8) busy_cycles++;
            tick();
            lat++;
        end
        check({tag, " latency"}, lat, 9);
        check({tag, " busy_cycles"}, busy_cycles, 8);
        check({tag, " busy_at_done"}, busy8, 0);
        check({tag, " sum"}, sum8, exp_sum);
        check({tag, " cout"}, cout8, exp_cout);
        tick();
        check({tag, " done_width"}, done8, 0);
        check({tag, " sum_held"}, sum8, exp_sum);
        check({tag, " cout_held"}, cout8, exp_cout);
    endtask

    initial begin
        int lat;
        int busy_cycles;
        int done_pulses;

        tick();
        tick();
        check("rst busy", busy8, 0);
        check("rst done", done8, 0);
        check("rst sum", sum8, 8'h00);
        check("rst cout", cout8, 0);
        check("rst busy1", busy1, 0);
        rst = 1'b0;
        tick();

        add8("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        add8("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        add8("5a_a5_c", 8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1);
        add8("3c_0f", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0);
        add8("ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

        // Start pulse in the middle of RUN must be ignored.
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        done_pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (done8) begin
                done_pulses++;
                check("ignore sum", sum8, 8'h30);
                check("ignore cout", cout8, 0);
            end
            tick();
        end
        check("ignore done_pulses", done_pulses, 1);
        check("ignore idle", busy8, 0);

        // Reset during RUN discards the result and suppresses done.
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstrun busy", busy8, 0);
        check("rstrun done", done8, 0);
        check("rstrun sum", sum8, 8'h00);
        check("rstrun cout", cout8, 0);
        done_pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8) done_pulses++;
            tick();
        end
        check("rstrun done_pulses", done_pulses, 0);
        add8("after_rst", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);

        // Reset asserted together with start wins.
        a8 = 8'h01; b8 = 8'h01; start8 = 1'b1; rst = 1'b1;
        tick();
        start8 = 1'b0; rst = 1'b0;
        check("rst_vs_start busy", busy8, 0);
        tick();

        // WIDTH=1 instance.
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        lat = 1;
        busy_cycles = 0;
        while (!done1 && lat < 20) begin
            if (busy1) busy_cycles++;
            tick();
            lat++;
        end
        check("w1 latency", lat, 2);
        check("w1 busy_cycles", busy_cycles, 1);
        check("w1 sum", sum1, 1);
        check("w1 cout", cout1, 1);
        tick();
        check("w1 done_width", done1, 0);
        check("w1 sum_held", sum1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
